keypad_scan_4x4: RTL
====================

// Module: keypad_scan_4x4
// PURPOSE
// Reader for the judge's 4x4 matrix keypad, the input-side counterpart of the seven-segment display path.
// Drives one column low at a time, samples the rows, debounces, and reports one code per key press.
// Codes feed the host controller (countdown preset / manual control); one key accepted at a time.
// PARAMETERS
// SCAN_DIV   50_000  clocks per scan tick (1 ms at 50 MHz); column dwell = 1 tick; must be >= 4
// DEB_TICKS  16      consecutive stable ticks required to accept a press and to accept a release; >= 2
// PORTS
// clk        in   1  system clock
// rst        in   1  asynchronous, active-high reset
// row        in   4  keypad rows, active-low, external pull-ups, asynchronous to clk
// col        out  4  keypad column drive, active-low, exactly one bit low at all times
// key_code   out  4  code of last accepted key = row_idx*4 + col_idx (row0/col0 = 0, row3/col3 = 15)
// key_valid  out  1  one-clk pulse when a press is accepted; key_code valid same cycle
// key_held   out  1  high from key_valid until the release is accepted
// BEHAVIOUR
// - Reset: col=4'b1110, col_idx=0, key_code=0, key_valid=0, key_held=0, state=SCAN, tick/deb counters=0.
// - row passes a 2-flop synchronizer (row_s); all decisions use row_s. Synchronizer resets to 4'b1111.
// - Tick: free-running divider, pulses 1 clk every SCAN_DIV clocks; all FSM actions occur on tick only.
// - SCAN: on tick, if row_s==4'b1111 advance col_idx (3 wraps to 0), col = ~(1<<col_idx).
//   If row_s has exactly one bit low: capture row_cap=row_s, hold column, deb_cnt=1, go DEBOUNCE.
//   If row_s has >1 bit low (ghost/multi-key): discard, advance column as if idle.
// - DEBOUNCE: on tick, row_s==row_cap -> deb_cnt++; deb_cnt reaching DEB_TICKS -> key_code=row_idx*4+col_idx,
//   key_valid=1 for one clk, key_held=1, release counter=0, go PRESSED.
//   Any other row_s value -> deb_cnt=0, go SCAN (column then advances on next tick), no output.
// - PRESSED: column held. On tick, row_s==4'b1111 -> rel_cnt++; any low bit -> rel_cnt=0.
//   rel_cnt reaching DEB_TICKS -> key_held=0, go SCAN. Second key pressed while held: ignored, no new code.
// - key_code holds its value until the next accepted press (not cleared on release).
// - Latency: press stable on pins -> key_valid within 2 clk + (4 + DEB_TICKS) ticks worst case; key_valid
//   asserts on the clk after the accepting tick.
// - Counters saturate-free: deb_cnt/rel_cnt width = clog2(DEB_TICKS+1), cleared on every state change.
// - Reset mid-operation (any state): immediate return to reset values; in-flight press never reported.
// - Bounce shorter than DEB_TICKS ticks never produces key_valid; no repeat/auto-repeat while held.
// TESTING (bench: SCAN_DIV=4, DEB_TICKS=3, keypad model ties row[r] low when col[c] low and key(r,c) down)
// 1 Reset: assert rst mid-scan -> col=1110, key_valid=0, key_held=0, key_code=0; no pulses for 40 clk.
// 2 Idle scan: no keys -> col cycles 1110,1101,1011,0111,1110 with period 4 clk each, key_valid never high.
// 3 Clean press key(2,1) for 200 clk -> exactly one key_valid pulse, key_code=9, key_held=1;
//   release -> key_held falls after 3 quiet ticks, col resumes rotation.
// 4 Bounce: key(0,3) toggles every 6 clk for 60 clk then stable -> single key_valid with key_code=3.
// 5 Ghost: key(1,0) and key(3,0) down together -> no key_valid; release one -> key_code=4 accepted.
// 6 Held + second key: hold key(3,3) (code 15), press key(0,0) meanwhile -> no new pulse, key_code stays 15.

Source files
------------

// File: rtl/keypad_scan_4x4_if.sv
// Keypad scanner bundle: the matrix pins plus the accepted-key report.
// The master side is the scanner; the slave side is the keypad/host.
interface keypad_scan_4x4_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (input row, output col, key_code, key_valid, key_held);
   modport slave  (output row, input col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: one column driven low per tick, rows synchronized,
// press and release each debounced over DEB_TICKS ticks, one code per press.
module keypad_scan_4x4 #(
   parameter int SCAN_DIV  = 50_000,
   parameter int DEB_TICKS = 16
) (
   input  logic              clk,
   input  logic              rst,
   keypad_scan_4x4_if.master kp
);
   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEB_TICKS + 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

   logic [3:0]    row_m_q, row_s_q;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;
   state_t        state_q, state_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [3:0]    col_q, col_d;
   logic [3:0]    row_cap_q, row_cap_d;
   logic [CW-1:0] deb_cnt_q, deb_cnt_d;
   logic [CW-1:0] rel_cnt_q, rel_cnt_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;
   logic [3:0]    row_low;
   logic          one_low;
   logic [1:0]    row_idx;

   assign tick       = (tick_cnt_q == TW'(SCAN_DIV - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   // Exactly one row low; more than one means ghosting or a multi-key press.
   assign row_low = ~row_s_q;
   assign one_low = (row_low != 4'h0) && ((row_low & (row_low - 4'd1)) == 4'h0);

   always_comb begin
      case (row_cap_q)
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      col_d       = col_q;
      row_cap_d   = row_cap_q;
      deb_cnt_d   = deb_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (one_low) begin
                  row_cap_d = row_s_q;
                  deb_cnt_d = CW'(1);
                  state_d   = DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 1'b1;
                  col_d     = ~(4'b0001 << col_idx_d);
               end
            end
            DEBOUNCE: begin
               if (row_s_q == row_cap_q) begin
                  if (deb_cnt_q == CW'(DEB_TICKS - 1)) begin
                     key_code_d  = {row_idx, col_idx_q};
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     deb_cnt_d   = '0;
                     rel_cnt_d   = '0;
                     state_d     = PRESSED;
                  end else begin
                     deb_cnt_d = deb_cnt_q + 1'b1;
                  end
               end else begin
                  deb_cnt_d = '0;
                  state_d   = SCAN;
               end
            end
            PRESSED: begin
               // Any low row, including a second key, restarts the release count.
               if (row_s_q == 4'hF) begin
                  if (rel_cnt_q == CW'(DEB_TICKS - 1)) begin
                     key_held_d = 1'b0;
                     rel_cnt_d  = '0;
                     state_d    = SCAN;
                  end else begin
                     rel_cnt_d = rel_cnt_q + 1'b1;
                  end
               end else begin
                  rel_cnt_d = '0;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_m_q     <= 4'hF;
         row_s_q     <= 4'hF;
         tick_cnt_q  <= '0;
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         col_q       <= 4'b1110;
         row_cap_q   <= 4'hF;
         deb_cnt_q   <= '0;
         rel_cnt_q   <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         row_m_q     <= kp.row;
         row_s_q     <= row_m_q;
         tick_cnt_q  <= tick_cnt_d;
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         col_q       <= col_d;
         row_cap_q   <= row_cap_d;
         deb_cnt_q   <= deb_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign kp.col       = col_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;
endmodule
